// File: rtl/libAlu.sv
// Operation codes shared by the execute-stage units.
package libAlu;

   localparam int unsigned ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'h0;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'h1;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'h2;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'h3;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'h4;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'h5;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'h6;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'h7;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'h8;
   localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 4'h9;
   localparam logic [ALU_CTRL_W-1:0] ALU_MULT = 4'hA;
   localparam logic [ALU_CTRL_W-1:0] ALU_DIV  = 4'hB;
   localparam logic [ALU_CTRL_W-1:0] ALU_MFHI = 4'hC;
   localparam logic [ALU_CTRL_W-1:0] ALU_MFLO = 4'hD;

endpackage

// File: rtl/libMulDiv.sv
// Types and constants for the iterative MULT/DIV engine.
package libMulDiv;

   typedef enum logic [1:0] {
      MD_IDLE   = 2'd0,
      MD_RUN    = 2'd1,
      MD_FINISH = 2'd2
   } mdState_t;

   typedef enum logic {
      MD_MULT = 1'b0,
      MD_DIV  = 1'b1
   } mdOp_t;

   // Fill bit for the LO value written on divide-by-zero (all ones by default).
   localparam logic MD_DIV0_FILL = 1'b1;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 magnitude datapath: shift-add multiply or restoring divide, one step per i_step.
module muldiv_iter_core
   import libMulDiv::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  mdOp_t              i_op,
   input  logic               i_init,
   input  logic               i_step,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [2*WIDTH-1:0] o_result
);

   localparam int unsigned W2 = 2 * WIDTH;

   mdOp_t             r_op;
   logic [WIDTH-1:0]  r_opnd;
   logic [W2-1:0]     r_acc;

   logic [WIDTH-1:0]  w_hi;
   logic [WIDTH-1:0]  w_lo;
   logic [WIDTH:0]    w_msum;
   logic [W2-1:0]     w_mul_next;
   logic [WIDTH:0]    w_shift;
   logic              w_ge;
   logic [WIDTH-1:0]  w_diff;
   logic [W2-1:0]     w_div_next;

   // Upper half is the running product (MULT) or partial remainder (DIV);
   // lower half holds the multiplier bits still to consume or the quotient being built.
   always_comb begin
      w_hi       = r_acc[W2-1:WIDTH];
      w_lo       = r_acc[WIDTH-1:0];
      w_msum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
      w_mul_next = {w_msum, w_lo[WIDTH-1:1]};
      w_shift    = {w_hi, w_lo[WIDTH-1]};
      w_ge       = (w_shift >= {1'b0, r_opnd});
      w_diff     = w_shift[WIDTH-1:0] - r_opnd;
      w_div_next = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), w_lo[WIDTH-2:0], w_ge};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_op   <= MD_MULT;
         r_opnd <= '0;
         r_acc  <= '0;
      end else if (i_init) begin
         r_op   <= i_op;
         r_opnd <= (i_op == MD_MULT) ? i_a : i_b;
         r_acc  <= {{WIDTH{1'b0}}, ((i_op == MD_MULT) ? i_b : i_a)};
      end else if (i_step) begin
         r_acc  <= (r_op == MD_MULT) ? w_mul_next : w_div_next;
      end
   end

   assign o_result = r_acc;

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// Iterative signed MULT/DIV engine owning HI/LO; stalls the core while an operation runs.
module hi_lo_muldiv_unit
   import libAlu::*;
   import libMulDiv::*;
#(
   parameter int unsigned     WIDTH   = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{MD_DIV0_FILL}}
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ALU_CTRL_W-1:0] aluControl,
   input  logic                  regHiLoWrite,
   input  logic [WIDTH-1:0]      operandA,
   input  logic [WIDTH-1:0]      operandB,
   output logic                  busy,
   output logic                  done,
   output logic                  stall,
   output logic [WIDTH-1:0]      hi,
   output logic [WIDTH-1:0]      lo,
   output logic [WIDTH-1:0]      mfResult
);

   localparam int unsigned      W2   = 2 * WIDTH;
   localparam int unsigned      CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   mdState_t          r_state;
   mdState_t          w_next;
   logic [CW-1:0]     r_cnt;
   mdOp_t             r_op;
   logic              r_sign_a;
   logic              r_sign_b;
   logic              r_b_zero;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_hi;
   logic [WIDTH-1:0]  r_lo;
   logic              r_done;

   logic              w_accept;
   logic              w_is_mf;
   logic              w_busy;
   mdOp_t             w_op_in;
   logic [WIDTH-1:0]  w_a_mag;
   logic [WIDTH-1:0]  w_b_mag;
   logic              w_init;
   logic              w_step;
   logic [W2-1:0]     w_raw;
   logic [W2-1:0]     w_prod;
   logic [WIDTH-1:0]  w_q;
   logic [WIDTH-1:0]  w_r;
   logic [WIDTH-1:0]  w_fin_hi;
   logic [WIDTH-1:0]  w_fin_lo;

   assign w_accept = start & regHiLoWrite & ((aluControl == ALU_MULT) | (aluControl == ALU_DIV));
   assign w_is_mf  = (aluControl == ALU_MFHI) | (aluControl == ALU_MFLO);
   assign w_busy   = (r_state != MD_IDLE);
   assign w_op_in  = (aluControl == ALU_DIV) ? MD_DIV : MD_MULT;
   // Unsigned magnitudes: the most negative value maps to 2^(WIDTH-1) without overflow.
   assign w_a_mag  = operandA[WIDTH-1] ? (-operandA) : operandA;
   assign w_b_mag  = operandB[WIDTH-1] ? (-operandB) : operandB;
   assign w_init   = (r_state == MD_IDLE) & w_accept;
   assign w_step   = (r_state == MD_RUN);

   always_ff @(posedge clock) begin
      if (!reset) r_state <= MD_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         MD_IDLE:   if (w_accept) w_next = MD_RUN;
         MD_RUN:    if (r_cnt == LAST) w_next = MD_FINISH;
         MD_FINISH: w_next = MD_IDLE;
         default:   w_next = MD_IDLE;
      endcase
   end

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clock    (clock),
      .reset    (reset),
      .i_op     (w_op_in),
      .i_init   (w_init),
      .i_step   (w_step),
      .i_a      (w_a_mag),
      .i_b      (w_b_mag),
      .o_result (w_raw)
   );

   // Sign correction of the raw magnitude result (C truncation semantics for DIV).
   always_comb begin
      w_prod   = (r_sign_a ^ r_sign_b) ? (-w_raw) : w_raw;
      w_q      = w_raw[WIDTH-1:0];
      w_r      = w_raw[W2-1:WIDTH];
      w_fin_hi = w_prod[W2-1:WIDTH];
      w_fin_lo = w_prod[WIDTH-1:0];
      if (r_op == MD_DIV) begin
         if (r_b_zero) begin
            w_fin_hi = r_a;
            w_fin_lo = DIV0_LO;
         end else begin
            w_fin_hi = r_sign_a ? (-w_r) : w_r;
            w_fin_lo = (r_sign_a ^ r_sign_b) ? (-w_q) : w_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_op     <= MD_MULT;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_b_zero <= 1'b0;
         r_a      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == MD_FINISH);
         if (w_init) begin
            r_cnt    <= '0;
            r_op     <= w_op_in;
            r_sign_a <= operandA[WIDTH-1];
            r_sign_b <= operandB[WIDTH-1];
            r_b_zero <= (operandB == '0);
            r_a      <= operandA;
         end else if (r_state == MD_RUN) begin
            r_cnt    <= r_cnt + CW'(1);
         end else if (r_state == MD_FINISH) begin
            r_hi     <= w_fin_hi;
            r_lo     <= w_fin_lo;
         end
      end
   end

   assign busy     = reset & w_busy;
   assign stall    = reset & (w_busy | w_init | (w_is_mf & w_busy));
   assign done     = r_done;
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign mfResult = (aluControl == ALU_MFHI) ? r_hi :
                     (aluControl == ALU_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Directed bench for hi_lo_muldiv_unit with hand-computed MULT/DIV results.
module tb_hi_lo_muldiv_unit;
   import libAlu::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  aluControl;
   logic        regHiLoWrite;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mfResult;

   int errors = 0;
   int checks = 0;

   hi_lo_muldiv_unit #(.WIDTH(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .aluControl   (aluControl),
      .regHiLoWrite (regHiLoWrite),
      .operandA     (operandA),
      .operandB     (operandB),
      .busy         (busy),
      .done         (done),
      .stall        (stall),
      .hi           (hi),
      .lo           (lo),
      .mfResult     (mfResult)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: plain op; mode 1: try a DIV start mid-flight; mode 2: hold MFHI behind the op.
   task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input int mode,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int busy_n, stall_n, done_n, done_at;
      logic mf_seen;
      logic [31:0] mf_val;
      busy_n = 0; stall_n = 0; done_n = 0; done_at = 0;
      mf_seen = 1'b0; mf_val = '0;
      @(negedge clock);
      start = 1'b1; regHiLoWrite = 1'b1; aluControl = ctl; operandA = a; operandB = b;
      #1;
      chk({tag, "_stall_accept"}, 64'(stall), 64'd1);
      @(posedge clock);
      @(negedge clock);
      regHiLoWrite = 1'b0;
      if (mode == 2) begin
         start = 1'b1; aluControl = ALU_MFHI;
      end else begin
         start = 1'b0; aluControl = ALU_ADD;
      end
      for (int c = 1; c <= 60; c++) begin
         if (mode == 1 && c == 5) begin
            start = 1'b1; regHiLoWrite = 1'b1; aluControl = ALU_DIV;
            operandA = 32'd100; operandB = 32'd3;
         end
         if (mode == 1 && c == 6) begin
            start = 1'b0; regHiLoWrite = 1'b0; aluControl = ALU_ADD;
         end
         #1;
         if (busy) busy_n++;
         if (stall) stall_n++;
         else if (!mf_seen) begin
            mf_seen = 1'b1; mf_val = mfResult;
         end
         if (done) begin
            done_n++;
            if (done_at == 0) done_at = c - 1;
         end
         @(negedge clock);
      end
      start = 1'b0; aluControl = ALU_ADD;
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
      chk({tag, "_stall_cycles"}, 64'(stall_n), 64'd33);
      chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
      chk({tag, "_latency"}, 64'(done_at), 64'd33);
      chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
      if (mode == 2) chk({tag, "_mfhi_after_stall"}, 64'(mf_val), 64'(exp_hi));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; aluControl = ALU_ADD; regHiLoWrite = 1'b0;
      operandA = '0; operandB = '0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      aluControl = ALU_MFHI; start = 1'b1;
      #1;
      chk("rst_mfresult", 64'(mfResult), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("idle_mfhi_stall", 64'(stall), 64'd0);
      start = 1'b0; aluControl = ALU_ADD;

      run_op("mult_7_m3", ALU_MULT, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult_min_min", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'h0000_0000);
      run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_min_m1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000);
      run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 0, 32'h0000_0005, 32'hFFFF_FFFF);
      chk("div0_no_x", 64'($isunknown({busy, done, stall, hi, lo, mfResult})), 64'd0);
      aluControl = ALU_MFLO;
      #1;
      chk("mflo_read", 64'(mfResult), 64'hFFFF_FFFF);
      aluControl = ALU_ADD;
      #1;
      chk("mf_none_zero", 64'(mfResult), 64'd0);

      run_op("mult_busy_start", ALU_MULT, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      // Abort: reset lands while the counter is at 10.
      @(negedge clock);
      start = 1'b1; regHiLoWrite = 1'b1; aluControl = ALU_MULT;
      operandA = 32'd12345; operandB = 32'd678;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0; regHiLoWrite = 1'b0; aluControl = ALU_ADD;
      repeat (10) @(negedge clock);
      #1;
      chk("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      chk("abort_stays_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
